// File: rtl/display_pkg.sv
// Shared definitions for the credit display front end: character codes,
// display modes, converter states and the double-dabble nibble correction.
`timescale 1ns/1ps
package display_pkg;

    localparam int CREDIT_W    = 10;
    // Four BCD nibbles worth of room; the thousands position only ever needs 2 bits
    localparam int BCD_W       = 14;
    localparam int SHIFT_W     = CREDIT_W + BCD_W;
    localparam int SHIFT_ITERS = 10;

    localparam logic [3:0] CODE_E     = 4'hA;
    localparam logic [3:0] CODE_N     = 4'hB;
    localparam logic [3:0] CODE_P     = 4'hC;
    localparam logic [3:0] CODE_DOT   = 4'hD;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_CREDIT = 2'b01,
        MODE_PROMPT = 2'b10,
        MODE_ERROR  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        CONV_IDLE   = 2'd0,
        CONV_SHIFT  = 2'd1,
        CONV_COMMIT = 2'd2
    } conv_state_t;

    // Double-dabble correction: a nibble of 5 or more gets 3 added before the shift
    function automatic logic [3:0] dabble_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/bcd_converter.sv
// Multi-cycle shift-add (double-dabble) binary to BCD converter.
// Starts by itself whenever the input differs from the last value it loaded;
// done is high for the single COMMIT cycle, when the BCD outputs are final.
`timescale 1ns/1ps
module bcd_converter
    import display_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CREDIT_W-1:0] bin,
    output logic                busy,
    output logic                done,
    output logic [3:0]          hundreds,
    output logic [3:0]          tens,
    output logic [3:0]          units,
    output logic                overflow
);

    conv_state_t         state_reg, state_next;
    logic [SHIFT_W-1:0]  shift_reg, shift_next;
    logic [SHIFT_W-1:0]  adjusted;
    logic [3:0]          iter_reg, iter_next;
    logic [CREDIT_W-1:0] last_reg, last_next;
    logic                busy_reg, busy_next;
    logic                start;

    // Correct the three low BCD nibbles; binary part and thousands bits pass through
    assign adjusted[CREDIT_W-1:0] = shift_reg[CREDIT_W-1:0];
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dabble
            assign adjusted[CREDIT_W + 4*gi +: 4] = dabble_adjust(shift_reg[CREDIT_W + 4*gi +: 4]);
        end
    endgenerate
    assign adjusted[SHIFT_W-1:CREDIT_W+12] = shift_reg[SHIFT_W-1:CREDIT_W+12];

    assign start = (state_reg == CONV_IDLE) && (bin != last_reg);

    // Next-state logic: load on a new value, 10 shift iterations, one commit cycle
    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        iter_next  = iter_reg;
        last_next  = last_reg;
        unique case (state_reg)
            CONV_IDLE: begin
                if (start) begin
                    shift_next = {{BCD_W{1'b0}}, bin};
                    last_next  = bin;
                    iter_next  = 4'd0;
                    state_next = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                shift_next = {adjusted[SHIFT_W-2:0], 1'b0};
                iter_next  = iter_reg + 4'd1;
                if (iter_reg == 4'(SHIFT_ITERS - 1)) begin
                    state_next = CONV_COMMIT;
                end
            end
            CONV_COMMIT: begin
                state_next = CONV_IDLE;
            end
            default: begin
                state_next = CONV_IDLE;
            end
        endcase
        // A change already waiting in IDLE keeps busy up, so back-to-back
        // conversions read as one continuous busy window
        busy_next = (state_next != CONV_IDLE) || (bin != last_next);
    end

    // Converter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= CONV_IDLE;
            shift_reg <= '0;
            iter_reg  <= 4'd0;
            last_reg  <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            iter_reg  <= iter_next;
            last_reg  <= last_next;
            busy_reg  <= busy_next;
        end
    end

    assign busy     = busy_reg;
    assign done     = (state_reg == CONV_COMMIT);
    assign units    = shift_reg[CREDIT_W     +: 4];
    assign tens     = shift_reg[CREDIT_W + 4 +: 4];
    assign hundreds = shift_reg[CREDIT_W + 8 +: 4];
    assign overflow = |shift_reg[SHIFT_W-1:CREDIT_W+12];

endmodule

// File: rtl/display_scanner.sv
// Credit display front end: converts credit to BCD and time-multiplexes four
// character codes onto one segment decoder with active-low digit enables.
`timescale 1ns/1ps
module display_scanner
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CREDIT_W-1:0] credit,
    input  logic [1:0]          mode,
    output logic [3:0]          code,
    output logic [3:0]          digit_en_n,
    output logic                busy
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int FRM_W = $clog2(BLINK_FRAMES + 1);

    logic [PRE_W-1:0] presc_reg;
    logic             tick;
    logic [1:0]       scan_reg;
    logic [FRM_W-1:0] frame_reg;
    logic             phase_reg;
    logic [3:0]       hund_reg, tens_reg, units_reg;
    logic             ovf_reg;
    logic [3:0]       code_reg, en_n_reg;

    logic             conv_done;
    logic [3:0]       conv_hund, conv_tens, conv_units;
    logic             conv_ovf;

    mode_t            mode_sel;
    logic [3:0]       char_sel [4];

    bcd_converter u_conv (
        .clk      (clk),
        .rst_n    (rst_n),
        .bin      (credit),
        .busy     (busy),
        .done     (conv_done),
        .hundreds (conv_hund),
        .tens     (conv_tens),
        .units    (conv_units),
        .overflow (conv_ovf)
    );

    assign tick = (presc_reg == PRE_W'(REFRESH_DIV - 1));

    // Display BCD register: only finished conversions are ever copied in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hund_reg  <= 4'd0;
            tens_reg  <= 4'd0;
            units_reg <= 4'd0;
            ovf_reg   <= 1'b0;
        end else if (conv_done) begin
            hund_reg  <= conv_hund;
            tens_reg  <= conv_tens;
            units_reg <= conv_units;
            ovf_reg   <= conv_ovf;
        end
    end

    // Refresh prescaler: wraps at REFRESH_DIV-1, producing one tick per digit slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PRE_W'(1);
        end
    end

    // Character selection per digit position for the current mode and data
    always_comb begin
        mode_sel = mode_t'(mode);
        for (int d = 0; d < 4; d++) begin
            char_sel[d] = CODE_BLANK;
        end
        case (mode_sel)
            MODE_CREDIT: begin
                if (ovf_reg) begin
                    char_sel[3] = CODE_E;
                    char_sel[2] = CODE_DOT;
                    char_sel[1] = CODE_E;
                    char_sel[0] = CODE_E;
                end else begin
                    char_sel[3] = hund_reg;
                    char_sel[2] = CODE_DOT;
                    char_sel[1] = tens_reg;
                    char_sel[0] = units_reg;
                end
            end
            MODE_PROMPT: begin
                char_sel[3] = CODE_E;
                char_sel[2] = CODE_N;
            end
            MODE_ERROR: begin
                char_sel[3] = phase_reg ? CODE_E : CODE_BLANK;
            end
            default: begin
                // OFF: all blank, scanning keeps running
            end
        endcase
    end

    // Scan register: scan_reg names the digit lit on the next tick; code and
    // enable are loaded together so a digit never shows another digit's code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_reg <= 2'd0;
            code_reg <= CODE_BLANK;
            en_n_reg <= 4'b1111;
        end else if (tick) begin
            scan_reg <= scan_reg + 2'd1;
            code_reg <= char_sel[scan_reg];
            en_n_reg <= ~(4'b0001 << scan_reg);
        end
    end

    // Blink timing: count frames on the tick lighting digit 3, toggle phase on wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_reg <= '0;
            phase_reg <= 1'b0;
        end else if (tick && (scan_reg == 2'd3)) begin
            if (frame_reg == FRM_W'(BLINK_FRAMES - 1)) begin
                frame_reg <= '0;
                phase_reg <= ~phase_reg;
            end else begin
                frame_reg <= frame_reg + FRM_W'(1);
            end
        end
    end

    assign code       = code_reg;
    assign digit_en_n = en_n_reg;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with REFRESH_DIV=4 and BLINK_FRAMES=2.
`timescale 1ns/1ps
module tb_display_scanner;
    import display_pkg::*;

    localparam int DIV    = 4;
    localparam int FRAMES = 2;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic [9:0] credit = 10'd0;
    logic [1:0] mode   = 2'b01;
    logic [3:0] code;
    logic [3:0] digit_en_n;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [3:0] cap_code [16];
    logic [3:0] cap_en   [16];
    bit         cap_ok;
    bit         idle_ok;
    logic [3:0] exp_c    [4];
    logic [3:0] exp_en;

    always #5 clk = ~clk;

    display_scanner #(.REFRESH_DIV(DIV), .BLINK_FRAMES(FRAMES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .credit     (credit),
        .mode       (mode),
        .code       (code),
        .digit_en_n (digit_en_n),
        .busy       (busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Sync to the start of a digit-0 slot and record one full frame at negedges
    task automatic capture_frame();
        int n;
        n = 0;
        while (digit_en_n == 4'b1110 && n < 100) begin @(negedge clk); n++; end
        while (digit_en_n != 4'b1110 && n < 200) begin @(negedge clk); n++; end
        cap_ok = (digit_en_n == 4'b1110);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            cap_code[i] = code;
            cap_en[i]   = digit_en_n;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        idle_ok = !busy;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (code !== 4'hF || digit_en_n !== 4'b1111 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values code=%h en=%b busy=%b want F 1111 0", code, digit_en_n, busy);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            exp_en = (c < 4) ? 4'b1111 : 4'b1110;
            checks++;
            if (digit_en_n !== exp_en || (c == 4 && code !== 4'h0)) begin
                errors++;
                $display("FAIL first_tick cycle=%0d en=%b code=%h want en=%b code=0", c, digit_en_n, code, exp_en);
            end
        end
        for (int n = 0; n < 40 && digit_en_n !== 4'b1011; n++) @(negedge clk);
        checks++;
        if (digit_en_n !== 4'b1011) begin
            errors++;
            $display("FAIL digit2_reach en=%b want 1011", digit_en_n);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (code !== 4'hF || digit_en_n !== 4'b1111) begin
            errors++;
            $display("FAIL async_reset code=%h en=%b want F 1111", code, digit_en_n);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (digit_en_n !== 4'b1110) begin
            errors++;
            $display("FAIL rerelease_tick en=%b want 1110", digit_en_n);
        end
    endtask

    task automatic test_overflow();
        logic [9:0] vals [2];
        vals[0] = 10'd1000;
        vals[1] = 10'd1023;
        exp_c[0] = 4'hA; exp_c[1] = 4'hA; exp_c[2] = 4'hD; exp_c[3] = 4'hA;
        for (int v = 0; v < 2; v++) begin
            @(negedge clk) credit = vals[v];
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL ovf_busy credit=%0d busy=%b want 1", vals[v], busy);
            end
            wait_idle();
            capture_frame();
            checks++;
            if (!idle_ok || !cap_ok) begin
                errors++;
                $display("FAIL ovf_sync idle=%b frame=%b want 1 1", idle_ok, cap_ok);
            end
            for (int i = 0; i < 16; i++) begin
                exp_en = ~(4'b0001 << (i / 4));
                checks++;
                if (cap_en[i] !== exp_en || cap_code[i] !== exp_c[i / 4]) begin
                    errors++;
                    $display("FAIL ovf_frame credit=%0d s%0d en=%b code=%h want en=%b code=%h",
                             vals[v], i, cap_en[i], cap_code[i], exp_en, exp_c[i / 4]);
                end
            end
        end
    endtask

    task automatic test_credit();
        int cnt;
        cnt = 0;
        @(negedge clk) credit = 10'd125;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        checks++;
        if (cnt != 11) begin
            errors++;
            $display("FAIL credit_busy cycles=%0d want 11", cnt);
        end
        exp_c[0] = 4'h5; exp_c[1] = 4'h2; exp_c[2] = 4'hD; exp_c[3] = 4'h1;
        capture_frame();
        checks++;
        if (!cap_ok) begin
            errors++;
            $display("FAIL credit_sync frame=%b want 1", cap_ok);
        end
        for (int i = 0; i < 16; i++) begin
            exp_en = ~(4'b0001 << (i / 4));
            checks++;
            if (cap_en[i] !== exp_en || cap_code[i] !== exp_c[i / 4]) begin
                errors++;
                $display("FAIL credit_frame s%0d en=%b code=%h want en=%b code=%h",
                         i, cap_en[i], cap_code[i], exp_en, exp_c[i / 4]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int  cnt;
        int  first_low;
        int  d;
        bit  ok;
        @(negedge clk) credit = 10'd0;
        @(negedge clk);
        wait_idle();
        checks++;
        if (!idle_ok) begin
            errors++;
            $display("FAIL b2b_zero_idle busy=%b want 0", busy);
        end
        cnt = 0;
        first_low = -1;
        @(negedge clk) credit = 10'd125;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            else if (first_low < 0) first_low = i;
            case (digit_en_n)
                4'b1110: d = 0;
                4'b1101: d = 1;
                4'b1011: d = 2;
                4'b0111: d = 3;
                default: d = -1;
            endcase
            ok = (d == 0 && (code inside {4'h0, 4'h5})) ||
                 (d == 1 && (code inside {4'h0, 4'h2, 4'h4})) ||
                 (d == 2 && code == 4'hD) ||
                 (d == 3 && (code inside {4'h0, 4'h1, 4'h3}));
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL b2b_code s%0d en=%b code=%h want one of 0.00/1.25/3.40", i, digit_en_n, code);
            end
            if (i == 4) credit = 10'd340;
        end
        checks++;
        if (cnt != 23 || first_low != 23) begin
            errors++;
            $display("FAIL b2b_busy cycles=%0d first_low=%0d want 23 23", cnt, first_low);
        end
        exp_c[0] = 4'h0; exp_c[1] = 4'h4; exp_c[2] = 4'hD; exp_c[3] = 4'h3;
        capture_frame();
        for (int i = 0; i < 16; i++) begin
            exp_en = ~(4'b0001 << (i / 4));
            checks++;
            if (!cap_ok || cap_en[i] !== exp_en || cap_code[i] !== exp_c[i / 4]) begin
                errors++;
                $display("FAIL b2b_frame s%0d en=%b code=%h want en=%b code=%h",
                         i, cap_en[i], cap_code[i], exp_en, exp_c[i / 4]);
            end
        end
    endtask

    task automatic test_prompt_off();
        @(negedge clk) mode = 2'b10;
        exp_c[0] = 4'hF; exp_c[1] = 4'hF; exp_c[2] = 4'hB; exp_c[3] = 4'hA;
        capture_frame();
        for (int i = 0; i < 16; i++) begin
            exp_en = ~(4'b0001 << (i / 4));
            checks++;
            if (!cap_ok || cap_en[i] !== exp_en || cap_code[i] !== exp_c[i / 4]) begin
                errors++;
                $display("FAIL prompt_frame s%0d en=%b code=%h want en=%b code=%h",
                         i, cap_en[i], cap_code[i], exp_en, exp_c[i / 4]);
            end
        end
        @(negedge clk) mode = 2'b00;
        capture_frame();
        for (int i = 0; i < 16; i++) begin
            exp_en = ~(4'b0001 << (i / 4));
            checks++;
            if (!cap_ok || cap_en[i] !== exp_en || cap_code[i] !== 4'hF) begin
                errors++;
                $display("FAIL off_frame s%0d en=%b code=%h want en=%b code=F",
                         i, cap_en[i], cap_code[i], exp_en);
            end
        end
    endtask

    task automatic test_error_blink();
        logic [3:0] want;
        @(negedge clk) begin mode = 2'b11; credit = 10'd777; end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midconv_busy busy=%b want 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || digit_en_n !== 4'b1111 || code !== 4'hF) begin
            errors++;
            $display("FAIL midconv_reset busy=%b en=%b code=%h want 0 1111 F", busy, digit_en_n, code);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int f = 0; f < 8; f++) begin
            capture_frame();
            want = (((f / 2) % 2) == 1) ? 4'hA : 4'hF;
            for (int i = 0; i < 16; i++) begin
                exp_en = ~(4'b0001 << (i / 4));
                checks++;
                if (!cap_ok || cap_en[i] !== exp_en ||
                    cap_code[i] !== ((i / 4 == 3) ? want : 4'hF)) begin
                    errors++;
                    $display("FAIL blink_frame f%0d s%0d en=%b code=%h want en=%b d3=%h",
                             f, i, cap_en[i], cap_code[i], exp_en, want);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_credit();
        test_back_to_back();
        test_prompt_off();
        test_error_blink();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
